// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Purpose  : Shared types and constants for the data-memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Arbiter operating mode: open round-robin or external burst lock.
  typedef enum logic [0:0] {
    ARB_S  = 1'b0,
    LOCK_S = 1'b1
  } arb_state_e;

  // Requester identifiers; also the bit positions in the picker vectors.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  // Width of the burst beat counter.
  localparam int BURST_W = 8;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Purpose  : Combinational two-way round-robin picker. On contention the
//             requester that was not granted last wins.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Single requester passes straight through; contention favours the other port.
  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      if (last == PORT_EXT) begin
        gnt[PORT_CPU] = 1'b1;
      end else begin
        gnt[PORT_EXT] = 1'b1;
      end
    end else begin
      gnt = req;
    end
  end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter
//  Purpose  : Shares the single-port data memory between the CPU load/store
//             path and an external loader/DMA port. One access per cycle,
//             round-robin with a bounded external burst lock. Stalls the CPU
//             while its access is outstanding.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_lock,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e           state_q, state_d;
  logic                 rr_last_q, rr_last_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                 cpu_rd_pend_q, cpu_rd_pend_d;
  logic                 ext_rd_pend_q, ext_rd_pend_d;
  logic [ADDR_W-1:0]    addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0]    wdata_hold_q, wdata_hold_d;

  logic                 cpu_req_eff;
  logic                 lock_exit;
  logic                 lock_hold;
  logic                 pick_last;
  logic [1:0]           pick_gnt;
  logic                 cpu_grant;
  logic                 ext_grant;

  // In a load-return cycle the CPU request still belongs to the finished load.
  assign cpu_req_eff = cpu_req & ~cpu_rd_pend_q;

  // Lock ends when the requester releases it or the beat budget is spent;
  // the exit decision is taken before this cycle's grant.
  assign lock_exit = (state_q == LOCK_S) &&
                     (!ext_lock || (burst_cnt_q == BURST_W'(MAX_BURST)));
  assign lock_hold = (state_q == LOCK_S) && !lock_exit;

  // Leaving a lock counts as an external grant so the CPU wins next.
  assign pick_last = lock_exit ? PORT_EXT : rr_last_q;

  rr_pick2 u_pick (
    .req  ({ext_req, cpu_req_eff}),
    .last (pick_last),
    .gnt  (pick_gnt)
  );

  // Grant selection: lock serves only the external port, reset grants nothing.
  always_comb begin
    cpu_grant = 1'b0;
    ext_grant = 1'b0;
    if (!rst) begin
      if (lock_hold) begin
        ext_grant = ext_req;
      end else begin
        cpu_grant = pick_gnt[PORT_CPU];
        ext_grant = pick_gnt[PORT_EXT];
      end
    end
  end

  // Memory port mux; address/data hold their last value when idle.
  always_comb begin
    mem_addr  = addr_hold_q;
    mem_wdata = wdata_hold_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_read  = ~cpu_we;
      mem_write = cpu_we;
    end else if (ext_grant) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_read  = ~ext_we;
      mem_write = ext_we;
    end
  end

  assign addr_hold_d  = mem_addr;
  assign wdata_hold_d = mem_wdata;

  assign cpu_stall  = ~rst & ((cpu_req_eff & ~cpu_grant) | (cpu_grant & ~cpu_we));
  assign ext_gnt    = ext_grant;
  assign ext_rvalid = ~rst & ext_rd_pend_q;
  assign ext_rdata  = ext_rvalid ? mem_rdata : '0;
  assign cpu_rdata  = (~rst & cpu_rd_pend_q) ? mem_rdata : '0;

  // Next-state: mode, round-robin pointer, beat counter and return flags.
  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    burst_cnt_d   = burst_cnt_q;
    cpu_rd_pend_d = cpu_grant & ~cpu_we;
    ext_rd_pend_d = ext_grant & ~ext_we;

    if (cpu_grant) begin
      rr_last_d = PORT_CPU;
    end else if (ext_grant || lock_exit) begin
      rr_last_d = PORT_EXT;
    end

    if (lock_hold) begin
      if (ext_grant) begin
        burst_cnt_d = burst_cnt_q + BURST_W'(1);
      end
    end else if (ext_grant && ext_lock) begin
      state_d     = LOCK_S;
      burst_cnt_d = BURST_W'(1);
    end else begin
      state_d     = ARB_S;
      burst_cnt_d = '0;
    end
  end

  // State registers with synchronous reset; CPU wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_S;
      rr_last_q     <= PORT_EXT;
      burst_cnt_q   <= '0;
      cpu_rd_pend_q <= 1'b0;
      ext_rd_pend_q <= 1'b0;
      addr_hold_q   <= '0;
      wdata_hold_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      burst_cnt_q   <= burst_cnt_d;
      cpu_rd_pend_q <= cpu_rd_pend_d;
      ext_rd_pend_q <= ext_rd_pend_d;
      addr_hold_q   <= addr_hold_d;
      wdata_hold_q  <= wdata_hold_d;
    end
  end

endmodule : data_mem_arbiter
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_arbiter
//  Purpose  : Self-checking bench for data_mem_arbiter with a behavioural
//             memory and a cycle-level reference model of the arbitration.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

  localparam int MAXB = 8;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, ext_gnt, ext_rvalid, mem_read, mem_write;
  logic [15:0] mem_rdata = '0;
  logic [15:0] mem [256] = '{default: '0};

  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
  end

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [256] = '{default: '0};
  bit          m_lock, m_last_ext, m_cpu_pend, m_ext_pend;
  int          m_beats;
  logic [15:0] m_cpu_data, m_ext_data, m_addr, m_wdata;

  bit          e_cpu_gnt, e_ext_gnt, e_in_lock;
  logic        e_mem_read, e_mem_write, e_cpu_stall, e_ext_rvalid;
  logic [15:0] e_mem_addr, e_mem_wdata, e_ext_rdata, e_cpu_rdata;

  task automatic model_eval();
    bit cpu_eff, leave;
    cpu_eff   = cpu_req && !m_cpu_pend;
    leave     = m_lock && (!ext_lock || m_beats >= MAXB);
    e_in_lock = m_lock && !leave;
    e_cpu_gnt = 0;
    e_ext_gnt = 0;
    if (!rst) begin
      if (e_in_lock)                e_ext_gnt = ext_req;
      else if (cpu_eff && ext_req) begin
        if (m_last_ext) e_cpu_gnt = 1; else e_ext_gnt = 1;
      end else begin
        e_cpu_gnt = cpu_eff;
        e_ext_gnt = ext_req;
      end
    end
    e_mem_read   = (e_cpu_gnt && !cpu_we) || (e_ext_gnt && !ext_we);
    e_mem_write  = (e_cpu_gnt && cpu_we)  || (e_ext_gnt && ext_we);
    e_mem_addr   = rst ? 16'h0 : e_cpu_gnt ? cpu_addr  : e_ext_gnt ? ext_addr  : m_addr;
    e_mem_wdata  = rst ? 16'h0 : e_cpu_gnt ? cpu_wdata : e_ext_gnt ? ext_wdata : m_wdata;
    e_cpu_stall  = !rst && ((cpu_eff && !e_cpu_gnt) || (e_cpu_gnt && !cpu_we));
    e_ext_rvalid = !rst && m_ext_pend;
    e_ext_rdata  = e_ext_rvalid ? m_ext_data : 16'h0;
    e_cpu_rdata  = (!rst && m_cpu_pend) ? m_cpu_data : 16'h0;
  endtask

  task automatic model_commit();
    if (rst) begin
      m_lock = 0; m_beats = 0; m_last_ext = 1; m_cpu_pend = 0; m_ext_pend = 0;
      m_addr = 0; m_wdata = 0;
      return;
    end
    m_cpu_pend = 0;
    m_ext_pend = 0;
    if (e_cpu_gnt) begin
      m_addr = cpu_addr; m_wdata = cpu_wdata; m_last_ext = 0;
      if (cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
      else begin m_cpu_pend = 1; m_cpu_data = ref_mem[cpu_addr[7:0]]; end
    end
    if (e_ext_gnt) begin
      m_addr = ext_addr; m_wdata = ext_wdata; m_last_ext = 1;
      if (ext_we) ref_mem[ext_addr[7:0]] = ext_wdata;
      else begin m_ext_pend = 1; m_ext_data = ref_mem[ext_addr[7:0]]; end
    end
    if (e_in_lock) begin
      if (e_ext_gnt) m_beats++;
    end else if (e_ext_gnt && ext_lock) begin
      m_lock = 1; m_beats = 1;
    end else begin
      m_lock = 0; m_beats = 0;
    end
  endtask

  function automatic logic [68:0] dut_vec();
    return {mem_read, mem_write, mem_addr, mem_wdata, cpu_stall, ext_gnt,
            ext_rvalid, ext_rdata, cpu_rdata};
  endfunction

  function automatic logic [68:0] exp_vec();
    return {e_mem_read, e_mem_write, e_mem_addr, e_mem_wdata, e_cpu_stall, e_ext_gnt,
            e_ext_rvalid, e_ext_rdata, e_cpu_rdata};
  endfunction

  // ---------------- cycle sequencing ----------------
  task automatic set_idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_lock = 0;
  endtask

  task automatic start_cycle();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic eval();
    #1;
    model_eval();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_commit();
  endtask

  task automatic reset_cycle();
    start_cycle(); rst = 1; set_idle(); eval(); finish_cycle();
  endtask

  task automatic cpu_store_alone(input logic [15:0] a);
    start_cycle(); set_idle(); cpu_req = 1; cpu_we = 1; cpu_addr = a; eval(); finish_cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    start_cycle(); rst = 1; cpu_req = 1; ext_req = 1; ext_lock = 1; eval();
    checks++;
    if ({mem_read, mem_write, cpu_stall, ext_gnt} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b want 0000", {mem_read, mem_write, cpu_stall, ext_gnt});
    end
    finish_cycle();
    start_cycle(); set_idle(); eval();
    checks++;
    if (dut_vec() !== 69'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", dut_vec());
    end
    finish_cycle();
  endtask

  task automatic test_cpu_load();
    start_cycle(); set_idle();
    ext_req = 1; ext_we = 1; ext_addr = 16'h0010; ext_wdata = 16'hBEEF; eval();
    checks++;
    if ({ext_gnt, mem_write, mem_addr} !== {1'b1, 1'b1, 16'h0010}) begin
      errors++; $display("FAIL ext_write got %h want %h", {ext_gnt, mem_write, mem_addr}, {1'b1, 1'b1, 16'h0010});
    end
    finish_cycle();
    start_cycle(); set_idle(); cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; eval();
    checks++;
    if ({mem_read, mem_addr, cpu_stall} !== {1'b1, 16'h0010, 1'b1}) begin
      errors++; $display("FAIL load_issue got %h want %h", {mem_read, mem_addr, cpu_stall}, {1'b1, 16'h0010, 1'b1});
    end
    finish_cycle();
    start_cycle(); eval();
    checks++;
    if ({mem_read, cpu_stall, cpu_rdata} !== {2'b00, 16'hBEEF}) begin
      errors++; $display("FAIL load_return got %h want %h", {mem_read, cpu_stall, cpu_rdata}, {2'b00, 16'hBEEF});
    end
    finish_cycle();
  endtask

  task automatic test_contention();
    reset_cycle();
    start_cycle(); set_idle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    ext_req = 1; ext_we = 0; ext_addr = 16'h0010; eval();
    checks++;
    if ({mem_write, mem_read, ext_gnt, cpu_stall, mem_addr} !== {4'b1000, 16'h0020}) begin
      errors++; $display("FAIL contend_first got %h want %h", {mem_write, mem_read, ext_gnt, cpu_stall, mem_addr}, {4'b1000, 16'h0020});
    end
    finish_cycle();
    start_cycle(); cpu_addr = 16'h0021; cpu_wdata = 16'h5678; eval();
    checks++;
    if ({ext_gnt, mem_read, mem_write, cpu_stall, mem_addr} !== {4'b1101, 16'h0010}) begin
      errors++; $display("FAIL contend_second got %h want %h", {ext_gnt, mem_read, mem_write, cpu_stall, mem_addr}, {4'b1101, 16'h0010});
    end
    finish_cycle();
    start_cycle(); ext_req = 0; eval();
    checks++;
    if ({mem_write, cpu_stall, ext_rvalid, ext_rdata, mem_addr} !== {3'b101, 16'hBEEF, 16'h0021}) begin
      errors++; $display("FAIL contend_third got %h want %h", {mem_write, cpu_stall, ext_rvalid, ext_rdata, mem_addr}, {3'b101, 16'hBEEF, 16'h0021});
    end
    finish_cycle();
    start_cycle(); set_idle(); cpu_req = 1; cpu_addr = 16'h0021; eval(); finish_cycle();
    start_cycle(); eval();
    checks++;
    if (cpu_rdata !== 16'h5678) begin
      errors++; $display("FAIL store_readback got %h want 5678", cpu_rdata);
    end
    finish_cycle();
  endtask

  task automatic test_lock_burst();
    int done = 0, rv = 0, cpu_at = -1, stalls = 0;
    reset_cycle();
    cpu_store_alone(16'h0030);
    for (int c = 0; c < 20; c++) begin
      start_cycle();
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'(c);
      if (done < 12) begin
        ext_req = 1; ext_we = 0; ext_addr = 16'h0040 + 16'(done); ext_lock = 1;
      end else begin
        ext_req = 0; ext_lock = 0;
      end
      eval();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL lock_burst cyc %0d got %h want %h", c, dut_vec(), exp_vec());
      end
      if (ext_gnt) done++;
      if (mem_write && cpu_at < 0) cpu_at = done;
      if (ext_rvalid) rv++;
      if (c < 8 && cpu_stall) stalls++;
      finish_cycle();
    end
    checks++;
    if (cpu_at !== 8) begin errors++; $display("FAIL burst_len got %0d want 8", cpu_at); end
    checks++;
    if (done !== 12) begin errors++; $display("FAIL burst_gnts got %0d want 12", done); end
    checks++;
    if (rv !== 12) begin errors++; $display("FAIL burst_rvalid got %0d want 12", rv); end
    checks++;
    if (stalls !== 8) begin errors++; $display("FAIL burst_stall got %0d want 8", stalls); end
  endtask

  task automatic test_lock_gap();
    int done = 0, cpu_at = -1;
    reset_cycle();
    cpu_store_alone(16'h0031);
    for (int c = 0; c < 16; c++) begin
      start_cycle();
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0031; cpu_wdata = 16'(c);
      ext_lock = (done < 10);
      ext_req  = (c == 3 || c == 4) ? 1'b0 : (done < 10);
      ext_we = 0; ext_addr = 16'h0050 + 16'(done);
      eval();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL lock_gap cyc %0d got %h want %h", c, dut_vec(), exp_vec());
      end
      if (c == 3 || c == 4) begin
        checks++;
        if ({ext_gnt, mem_read, mem_write, cpu_stall} !== 4'b0001) begin
          errors++; $display("FAIL gap_hold cyc %0d got %b want 0001", c, {ext_gnt, mem_read, mem_write, cpu_stall});
        end
      end
      if (ext_gnt) done++;
      if (mem_write && cpu_at < 0) cpu_at = done;
      finish_cycle();
    end
    checks++;
    if (cpu_at !== 8) begin errors++; $display("FAIL gap_burst_len got %0d want 8", cpu_at); end
  endtask

  task automatic test_reset_mid();
    reset_cycle();
    start_cycle(); set_idle(); cpu_req = 1; cpu_addr = 16'h0021; eval(); finish_cycle();
    start_cycle(); rst = 1; ext_req = 1; ext_lock = 1; eval();
    checks++;
    if (dut_vec() !== 69'h0) begin
      errors++; $display("FAIL rst_after_cpu_read got %h want 0", dut_vec());
    end
    finish_cycle();
    start_cycle(); set_idle(); ext_req = 1; ext_lock = 1; ext_addr = 16'h0010; eval();
    checks++;
    if ({ext_gnt, mem_read} !== 2'b11) begin
      errors++; $display("FAIL ext_lock_issue got %b want 11", {ext_gnt, mem_read});
    end
    finish_cycle();
    start_cycle(); rst = 1; set_idle(); eval();
    checks++;
    if ({ext_rvalid, ext_rdata} !== 17'h0) begin
      errors++; $display("FAIL rst_drop_rvalid got %h want 0", {ext_rvalid, ext_rdata});
    end
    finish_cycle();
    start_cycle(); set_idle(); eval();
    checks++;
    if (dut_vec() !== 69'h0) begin
      errors++; $display("FAIL post_rst_idle got %h want 0", dut_vec());
    end
    finish_cycle();
    start_cycle(); cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0022;
    ext_req = 1; ext_lock = 1; ext_addr = 16'h0010; eval();
    checks++;
    if ({mem_write, ext_gnt, cpu_stall} !== 3'b100) begin
      errors++; $display("FAIL post_rst_arb got %b want 100", {mem_write, ext_gnt, cpu_stall});
    end
    finish_cycle();
  endtask

  task automatic test_random();
    bit ext_wait = 0;
    reset_cycle();
    for (int c = 0; c < 600; c++) begin
      start_cycle();
      rst       = ($urandom_range(0, 99) == 0);
      cpu_req   = ($urandom_range(0, 9) < 6);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'($urandom_range(0, 63));
      cpu_wdata = 16'($urandom);
      if (!ext_wait) begin
        ext_req   = 1'($urandom_range(0, 1));
        ext_we    = 1'($urandom_range(0, 1));
        ext_addr  = 16'($urandom_range(0, 63));
        ext_wdata = 16'($urandom);
      end
      ext_lock = ($urandom_range(0, 9) < 7);
      eval();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d got %h want %h", c, dut_vec(), exp_vec());
      end
      ext_wait = ext_req && !e_ext_gnt && !rst;
      finish_cycle();
    end
  endtask

  initial begin
    rst = 1;
    set_idle();
    m_lock = 0; m_beats = 0; m_last_ext = 1; m_cpu_pend = 0; m_ext_pend = 0;
    m_addr = 0; m_wdata = 0; m_cpu_data = 0; m_ext_data = 0;
    test_reset();
    test_cpu_load();
    test_contention();
    test_lock_burst();
    test_lock_gap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_data_mem_arbiter
`default_nettype wire
